// File: rtl/dds_cfg_ctrl.sv
// DDS configuration controller: validates decoded freq/wave requests, converts
// frequency to a tuning word with a shift-add multiplier, commits on phase wrap.
module dds_cfg_ctrl #(
  parameter int unsigned FTW_K     = 5_629_500,
  parameter int unsigned FTW_SHIFT = 16,
  parameter int unsigned FREQ_MAX  = 25_000_000,
  parameter int unsigned WRAP_TMO  = 1024,
  parameter int unsigned RST_FREQ  = 500_000,
  parameter int unsigned RST_FTW   = 42_949_676
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [23:0] freq,
  input  logic [7:0]  wave,
  input  logic        phase_wrap,
  output logic [31:0] ftw,
  output logic [1:0]  wave_sel,
  output logic        cfg_update,
  output logic        cfg_err,
  output logic        busy
);
  localparam int AW = 47;
  localparam int CW = $clog2(WRAP_TMO + 1);

  typedef enum logic [2:0] {IDLE, CHECK, MUL, WAIT_WRAP, APPLY} state_t;
  state_t state, state_nxt;

  logic [23:0]   req_f;
  logic [7:0]    req_w;
  logic [AW-1:0] acc, mcand;
  logic [23:0]   mplier;
  logic [4:0]    iter;
  logic [CW-1:0] wcnt;
  logic          req_chg, req_bad, mul_last, wrap_go;
  logic [31:0]   new_ftw;

  assign req_chg  = {freq, wave} != {req_f, req_w};
  assign req_bad  = ({8'd0, req_f} > FREQ_MAX) || (req_w > 8'd3);
  assign mul_last = iter == 5'd23;
  // A zero tuning word freezes the accumulator, so no wrap would ever arrive.
  assign wrap_go  = phase_wrap || (ftw == 32'd0) || (wcnt == CW'(WRAP_TMO - 1));
  assign new_ftw  = 32'(acc >> FTW_SHIFT);
  assign busy     = state != IDLE;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (req_chg)  state_nxt = CHECK;
      CHECK:     state_nxt = req_bad ? IDLE : MUL;
      MUL:       if (mul_last) state_nxt = WAIT_WRAP;
      WAIT_WRAP: if (wrap_go)  state_nxt = APPLY;
      APPLY:     state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      req_f      <= 24'(RST_FREQ);
      req_w      <= 8'd0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      iter       <= '0;
      wcnt       <= '0;
      ftw        <= 32'(RST_FTW);
      wave_sel   <= 2'd0;
      cfg_update <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      cfg_err    <= 1'b0;
      case (state)
        IDLE: if (req_chg) begin
          req_f <= freq;
          req_w <= wave;
        end
        CHECK: begin
          if (req_bad) cfg_err <= 1'b1;
          else begin
            acc    <= '0;
            mcand  <= AW'(FTW_K);
            mplier <= req_f;
            iter   <= '0;
          end
        end
        MUL: begin
          // LSB-first: multiplicand doubles as the multiplier drains right.
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          iter   <= iter + 5'd1;
          wcnt   <= '0;
        end
        WAIT_WRAP: wcnt <= wcnt + 1'b1;
        APPLY: begin
          ftw        <= new_ftw;
          wave_sel   <= req_w[1:0];
          cfg_update <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dds_cfg_ctrl.sv
// Self-checking bench for dds_cfg_ctrl: directed scenarios plus randomized
// requests checked against an arithmetic reference model.
module tb_dds_cfg_ctrl;
  localparam int unsigned FTW_K     = 5_629_500;
  localparam int unsigned FTW_SHIFT = 16;
  // Lowered so the range check is reachable from a 24-bit frequency port.
  localparam int unsigned FREQ_MAX  = 10_000_000;
  localparam int unsigned WRAP_TMO  = 1024;
  localparam int unsigned RST_FTW   = 42_949_676;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [23:0] freq = 24'd500_000;
  logic [7:0]  wave = 8'd0;
  logic        phase_wrap;
  logic [31:0] ftw;
  logic [1:0]  wave_sel;
  logic        cfg_update, cfg_err, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic pw_level = 1'b0;
  logic rand_pw = 1'b0;

  int          upd_cyc[$];
  logic [31:0] upd_ftw[$];
  logic [1:0]  upd_ws[$];
  int          err_cyc[$];

  // model state: last request captured and applied configuration
  int unsigned sh_f = 500_000;
  int unsigned sh_w = 0;
  logic [31:0] ap_ftw = RST_FTW;
  logic [1:0]  ap_ws = 2'd0;

  dds_cfg_ctrl #(.FTW_K(FTW_K), .FTW_SHIFT(FTW_SHIFT), .FREQ_MAX(FREQ_MAX),
                 .WRAP_TMO(WRAP_TMO), .RST_FREQ(500_000), .RST_FTW(RST_FTW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .freq(freq), .wave(wave),
    .phase_wrap(phase_wrap), .ftw(ftw), .wave_sel(wave_sel),
    .cfg_update(cfg_update), .cfg_err(cfg_err), .busy(busy));

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  initial phase_wrap = 1'b0;
  always @(negedge sys_clk) phase_wrap = rand_pw ? ($urandom_range(0, 7) == 0) : pw_level;

  always @(negedge sys_clk) begin
    if (cfg_update) begin
      upd_cyc.push_back(cyc);
      upd_ftw.push_back(ftw);
      upd_ws.push_back(wave_sel);
    end
    if (cfg_err) err_cyc.push_back(cyc);
  end

  function automatic logic [31:0] model_ftw(int unsigned f);
    longint unsigned p;
    p = longint'(f) * longint'(FTW_K);
    return 32'(p >> FTW_SHIFT);
  endfunction

  function automatic bit model_valid(int unsigned f, int unsigned w);
    return (f <= FREQ_MAX) && (w <= 3);
  endfunction

  task automatic clear_q();
    upd_cyc.delete(); upd_ftw.delete(); upd_ws.delete(); err_cyc.delete();
  endtask

  task automatic drive(input int unsigned f, input int unsigned w, output int c);
    @(negedge sys_clk);
    freq = 24'(f);
    wave = 8'(w);
    c = cyc;
    sh_f = f;
    sh_w = w;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    repeat (2) @(negedge sys_clk);
    while (busy && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s: busy still high after %0d cycles", name, budget);
    end
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (ftw !== 32'd42_949_676) begin errors++; $display("FAIL reset_ftw: got %0d want 42949676", ftw); end
    checks++;
    if (wave_sel !== 2'd0 || busy !== 1'b0 || cfg_update !== 1'b0 || cfg_err !== 1'b0) begin
      errors++; $display("FAIL reset_outs: wave_sel=%0d busy=%b upd=%b err=%b want 0", wave_sel, busy, cfg_update, cfg_err);
    end
    sys_rst_n = 1'b1;
    clear_q();
    repeat (100) @(negedge sys_clk);
    checks++;
    if (upd_cyc.size() != 0 || err_cyc.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_quiet: updates=%0d errs=%0d busy=%b want 0/0/0", upd_cyc.size(), err_cyc.size(), busy);
    end
  endtask

  task automatic test_apply_basic();
    int c;
    pw_level = 1'b1;
    @(negedge sys_clk);
    clear_q();
    drive(1_000_000, 2, c);
    @(negedge sys_clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_idle("basic", 100);
    checks++;
    if (upd_cyc.size() != 1) begin errors++; $display("FAIL basic_pulses: got %0d want 1", upd_cyc.size()); end
    else begin
      checks++;
      if (upd_cyc[0] != c + 28) begin errors++; $display("FAIL basic_latency: got %0d want %0d", upd_cyc[0] - c - 1, 27); end
    end
    checks++;
    if (ftw !== model_ftw(1_000_000) || ftw !== 32'd85_899_353) begin
      errors++; $display("FAIL basic_ftw: got %0d want 85899353", ftw);
    end
    checks++;
    if (wave_sel !== 2'd2) begin errors++; $display("FAIL basic_wave: got %0d want 2", wave_sel); end
    ap_ftw = model_ftw(1_000_000);
    ap_ws = 2'd2;
  endtask

  task automatic test_reject();
    int c;
    int unsigned fs[2] = '{15_000_000, 1000};
    int unsigned ws[2] = '{1, 5};
    for (int i = 0; i < 2; i++) begin
      clear_q();
      drive(fs[i], ws[i], c);
      repeat (3) @(negedge sys_clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reject%0d_busy: got %b at E+2 want 0", i, busy); end
      repeat (3) @(negedge sys_clk);
      checks++;
      if (err_cyc.size() != 1 || err_cyc[0] != c + 2) begin
        errors++; $display("FAIL reject%0d_err: count=%0d cyc=%0d want 1 at %0d", i, err_cyc.size(),
                           (err_cyc.size() > 0) ? err_cyc[0] : -1, c + 2);
      end
      checks++;
      if (upd_cyc.size() != 0 || ftw !== ap_ftw || wave_sel !== ap_ws) begin
        errors++; $display("FAIL reject%0d_hold: updates=%0d ftw=%0d ws=%0d want 0/%0d/%0d", i,
                           upd_cyc.size(), ftw, wave_sel, ap_ftw, ap_ws);
      end
    end
  endtask

  task automatic test_timeout();
    int c;
    pw_level = 1'b0;
    @(negedge sys_clk);
    clear_q();
    drive(1000, 0, c);
    wait_idle("timeout", 1200);
    checks++;
    if (upd_cyc.size() != 1 || upd_cyc[0] != c + 1 + 26 + WRAP_TMO) begin
      errors++; $display("FAIL timeout_cyc: count=%0d cyc=%0d want 1 at %0d", upd_cyc.size(),
                         (upd_cyc.size() > 0) ? upd_cyc[0] : -1, c + 1 + 26 + WRAP_TMO);
    end
    checks++;
    if (ftw !== 32'd85_899 || ftw !== model_ftw(1000)) begin errors++; $display("FAIL timeout_ftw: got %0d want 85899", ftw); end
    ap_ftw = ftw;
    ap_ws = 2'd0;
  endtask

  task automatic test_zero();
    int c;
    clear_q();
    drive(0, 1, c);
    wait_idle("zero_a", 1200);
    checks++;
    if (upd_cyc.size() != 1 || ftw !== 32'd0 || wave_sel !== 2'd1) begin
      errors++; $display("FAIL zero_apply: count=%0d ftw=%0d ws=%0d want 1/0/1", upd_cyc.size(), ftw, wave_sel);
    end
    clear_q();
    drive(1000, 1, c);
    wait_idle("zero_b", 1200);
    checks++;
    if (upd_cyc.size() != 1 || upd_cyc[0] != c + 28) begin
      errors++; $display("FAIL zero_nowait: count=%0d cyc=%0d want 1 at %0d", upd_cyc.size(),
                         (upd_cyc.size() > 0) ? upd_cyc[0] : -1, c + 28);
    end
    checks++;
    if (ftw !== model_ftw(1000)) begin errors++; $display("FAIL zero_ftw2: got %0d want %0d", ftw, model_ftw(1000)); end
    ap_ftw = ftw;
    ap_ws = 2'd1;
  endtask

  task automatic test_back_to_back();
    int c0, c;
    pw_level = 1'b1;
    repeat (2) @(negedge sys_clk);
    clear_q();
    drive(1000, 3, c0);
    repeat (4) @(negedge sys_clk);
    drive(2000, 3, c);
    repeat (4) @(negedge sys_clk);
    drive(3000, 3, c);
    repeat (30) @(negedge sys_clk);
    wait_idle("burst", 200);
    checks++;
    if (upd_cyc.size() != 2) begin errors++; $display("FAIL burst_count: got %0d want 2", upd_cyc.size()); end
    else begin
      checks++;
      if (upd_ftw[0] !== model_ftw(1000) || upd_ftw[1] !== model_ftw(3000) || upd_ws[1] !== 2'd3) begin
        errors++; $display("FAIL burst_vals: got %0d,%0d want %0d,%0d", upd_ftw[0], upd_ftw[1], model_ftw(1000), model_ftw(3000));
      end
      checks++;
      if (upd_cyc[0] != c0 + 28 || upd_cyc[1] != c0 + 56) begin
        errors++; $display("FAIL burst_cyc: got %0d,%0d want %0d,%0d", upd_cyc[0], upd_cyc[1], c0 + 28, c0 + 56);
      end
      checks++;
      if (upd_ftw[0] === model_ftw(2000) || upd_ftw[1] === model_ftw(2000)) begin
        errors++; $display("FAIL burst_drop: 2000 Hz word %0d was applied", model_ftw(2000));
      end
    end
    ap_ftw = model_ftw(3000);
    ap_ws = 2'd3;
  endtask

  task automatic test_reset_mid();
    int c;
    clear_q();
    drive(5000, 0, c);
    repeat (10) @(negedge sys_clk);
    #1 sys_rst_n = 1'b0;
    freq = 24'd500_000;
    wave = 8'd0;
    #1;
    checks++;
    if (ftw !== 32'(RST_FTW) || wave_sel !== 2'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset: ftw=%0d ws=%0d busy=%b want %0d/0/0", ftw, wave_sel, busy, RST_FTW);
    end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    sh_f = 500_000; sh_w = 0;
    ap_ftw = RST_FTW; ap_ws = 2'd0;
    repeat (50) @(negedge sys_clk);
    checks++;
    if (upd_cyc.size() != 0 || busy !== 1'b0 || ftw !== 32'(RST_FTW)) begin
      errors++; $display("FAIL midreset_quiet: updates=%0d busy=%b ftw=%0d", upd_cyc.size(), busy, ftw);
    end
  endtask

  task automatic test_random();
    int c;
    int unsigned f, w;
    rand_pw = 1'b1;
    for (int i = 0; i < 12; i++) begin
      f = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 24'hFF_FFFF) : $urandom_range(0, 2_000_000);
      w = $urandom_range(0, 4);
      if (f == sh_f && w == sh_w) f = f ^ 1;
      clear_q();
      drive(f, w, c);
      wait_idle("random", 1200);
      if (model_valid(f, w)) begin
        ap_ftw = model_ftw(f);
        ap_ws = 2'(w);
        checks++;
        if (upd_cyc.size() != 1 || err_cyc.size() != 0 || upd_cyc[0] < c + 28 || upd_cyc[0] > c + 27 + WRAP_TMO) begin
          errors++; $display("FAIL rand%0d_commit: f=%0d w=%0d updates=%0d errs=%0d", i, f, w, upd_cyc.size(), err_cyc.size());
        end
      end else begin
        checks++;
        if (upd_cyc.size() != 0 || err_cyc.size() != 1) begin
          errors++; $display("FAIL rand%0d_reject: f=%0d w=%0d updates=%0d errs=%0d want 0/1", i, f, w, upd_cyc.size(), err_cyc.size());
        end
      end
      checks++;
      if (ftw !== ap_ftw || wave_sel !== ap_ws) begin
        errors++; $display("FAIL rand%0d_cfg: f=%0d w=%0d ftw=%0d ws=%0d want %0d/%0d", i, f, w, ftw, wave_sel, ap_ftw, ap_ws);
      end
    end
    rand_pw = 1'b0;
  endtask

  initial begin
    test_reset();
    test_apply_basic();
    test_reject();
    test_timeout();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
